control_unit: RTL

//  Hardwired Moore sequencer that drives every control input of Datapath (fetch/decode/execute, T0..T7).

---
 rtl/cu_pkg.sv | 67 ++++++
 rtl/control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit.
// Holds opcode values, the sequencer state encoding, instruction classes
// and the opcode-to-class decode function.
package cu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd7;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd9;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd10;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd16;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd17;
  localparam logic [OP_W-1:0] OP_BR   = 5'd18;
  localparam logic [OP_W-1:0] OP_JR   = 5'd19;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd20;
  localparam logic [OP_W-1:0] OP_IN   = 5'd21;
  localparam logic [OP_W-1:0] OP_OUT  = 5'd22;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd23;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd24;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd25;
  localparam logic [OP_W-1:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } class_t;

  function automatic class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_LD:                          return C_LD;
      OP_LDI:                         return C_LDI;
      OP_ST:                          return C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:       return C_ALU_I;
      OP_MUL, OP_DIV:                 return C_MULDIV;
      OP_NEG, OP_NOT:                 return C_NEGNOT;
      OP_BR:                          return C_BR;
      OP_JR:                          return C_JR;
      OP_JAL:                         return C_JAL;
      OP_IN:                          return C_IN;
      OP_OUT:                         return C_OUT;
      OP_MFHI:                        return C_MFHI;
      OP_MFLO:                        return C_MFLO;
      OP_HALT:                        return C_HALT;
      default:                        return C_NOP;  // nop and 27..31
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving every Datapath control input.
// Fetch T0..T2, dispatch at T3 on IR[31:27], execute up to T7.
// Ports:
//   Clock, clear_n (sync, active-low)   clock / reset
//   IR[31:0], CON_FF, Stop               instruction, branch condition, halt request
//   Run, clear, opcode[OPW-1:0]          status, datapath clear, ALU operation
//   bus drivers, register loads, misc    one-bit strobes decoded from {state,class}
//
// state   | meaning
// RESET   | datapath clear asserted, waiting for clear_n release
// T0..T2  | instruction fetch (T1 is a memory state)
// T3..T7  | execute, length depends on instruction class
// HALT    | stopped, all strobes low, left only by reset
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPW      = 5
) (
  input  logic           Clock,
  input  logic           clear_n,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Stop,
  output logic           Run,
  output logic           clear,
  output logic [OPW-1:0] opcode,
  output logic           PCout, Zlowout, Zhighout, MDRout, HIout,
  output logic           LOout, InportOut, Cout, BAout, Rout,
  output logic           MARin, Zin, PCin, MDRin, IRin, Yin,
  output logic           LOin, HIin, Rin, CONin, OutportIn,
  output logic           IncPC, Read, Write, GRA, GRB, GRC
);

  localparam logic [2:0] WAIT_TC = 3'(MEM_WAIT);

  state_t          r_state;
  state_t          w_next;
  state_t          w_fin;
  class_t          w_class;
  logic [OP_W-1:0] w_op;
  logic [OP_W-1:0] w_alu_op;
  logic [2:0]      r_wait;
  logic            r_stop;
  logic            w_mem;
  logic            w_hold;
  logic            w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_class     = op_class(w_op);
  assign w_unused_ir = ^IR[26:0];

  // Memory states stretch by MEM_WAIT cycles; the counter restarts on every move.
  assign w_mem  = (r_state == S_T1) ||
                  (r_state == S_T6 && w_class == C_LD) ||
                  (r_state == S_T7 && w_class == C_ST);
  assign w_hold = w_mem && (r_wait != WAIT_TC);

  // Instruction boundary: a pending stop (latched or current) diverts to HALT.
  assign w_fin = (r_stop || Stop) ? S_HALT : S_T0;

  always_ff @(posedge Clock) begin
    if (!clear_n) begin
      r_state <= S_RESET;
      r_wait  <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_hold ? r_wait + 3'd1 : '0;
      r_stop  <= r_stop | Stop;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = w_hold ? S_T1 : S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        case (w_class)
          C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST,
          C_MULDIV, C_NEGNOT, C_BR, C_JAL: w_next = S_T4;
          C_HALT:                          w_next = S_HALT;
          default:                         w_next = w_fin;
        endcase
      end
      S_T4:    w_next = (w_class == C_NEGNOT || w_class == C_JAL) ? w_fin : S_T5;
      S_T5: begin
        case (w_class)
          C_ALU_R, C_ALU_I, C_LDI: w_next = w_fin;
          default:                 w_next = S_T6;
        endcase
      end
      S_T6: begin
        if (w_class == C_LD || w_class == C_ST) w_next = w_hold ? S_T6 : S_T7;
        else                                    w_next = w_fin;
      end
      S_T7:    w_next = w_hold ? S_T7 : w_fin;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    Run = 1'b0; clear = 1'b0; w_alu_op = '0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InportOut = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    LOin = 1'b0; HIin = 1'b0; Rin = 1'b0; CONin = 1'b0; OutportIn = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;

    Run   = (r_state != S_RESET) && (r_state != S_HALT);
    clear = (r_state == S_RESET);

    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (w_class)
          C_ALU_R, C_ALU_I: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LD, C_LDI, C_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_MULDIV: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_NEGNOT: begin GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_op = w_op; end
          C_BR:     begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:     begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL:    begin PCout = 1'b1; GRB = 1'b1; Rin = 1'b1; end
          C_IN:     begin InportOut = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_OUT:    begin GRA = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
          C_MFHI:   begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_MFLO:   begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_class)
          C_ALU_R:  begin GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_op = w_op; end
          C_ALU_I: begin
            Cout = 1'b1; Zin = 1'b1;
            w_alu_op = (w_op == OP_ANDI) ? OP_AND : (w_op == OP_ORI) ? OP_OR : OP_ADD;
          end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; w_alu_op = OP_ADD; end
          C_MULDIV: begin GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_op = w_op; end
          C_NEGNOT: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_BR:     begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:    begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_class)
          C_ALU_R, C_ALU_I, C_LDI: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
          C_BR:       begin Cout = 1'b1; Zin = 1'b1; w_alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_class)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          C_BR:     begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_class)
          C_LD:    begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    opcode = OPW'(w_alu_op);
  end

endmodule
